pipelined_adder_tree: RTL and testbench

- Parametrised, pipelined multi-operand unsigned adder. It is the successor to the fixed 3-bit two-operand adder.
- Sums NUM_OPERANDS values of WIDTH bits per beat through a registered binary tree.
- Optionally accumulates beat sums across a multi-beat packet into a saturating ACC_WIDTH result.
- Used by the cell-update datapath for neighbour-count and population reduction, behind valid/ready handshakes.

---
 rtl/pipelined_adder_tree.sv | 112 +++++++++++
 tb/tb_pipelined_adder_tree.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree.sv
// Pipelined multi-operand unsigned adder: a registered binary tree reduces one beat
// per cycle, and beat sums are accumulated per packet into a saturating result.
module pipelined_adder_tree #(
  parameter int WIDTH        = 3,
  parameter int NUM_OPERANDS = 8,
  parameter int ACC_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_OPERANDS*WIDTH-1:0] in_operands,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_sum,
  output logic                          out_overflow
);

  localparam int LEVELS    = $clog2(NUM_OPERANDS);
  localparam int SUM_WIDTH = WIDTH + LEVELS;
  localparam int NODES     = NUM_OPERANDS - 1;
  localparam int TOP_BASE  = (NODES - 1) * SUM_WIDTH;
  localparam int PAD       = ACC_WIDTH + 1 - SUM_WIDTH;

  // Tree levels 1..LEVELS are packed back to back; level k holds NUM_OPERANDS>>k nodes.
  function automatic int level_base(input int k);
    return (NUM_OPERANDS - 2 * (NUM_OPERANDS >> k)) * SUM_WIDTH;
  endfunction

  logic [NODES*SUM_WIDTH-1:0] node_d;
  logic [NODES*SUM_WIDTH-1:0] node_q;
  logic [LEVELS-1:0]          stage_valid;
  logic [LEVELS-1:0]          stage_last;
  logic                       advance;
  logic [ACC_WIDTH-1:0]       acc;
  logic                       ovf;
  logic [SUM_WIDTH-1:0]       tree_sum;
  logic [ACC_WIDTH:0]         total;
  logic                       carry;
  logic [ACC_WIDTH-1:0]       sat_sum;
  logic                       final_valid;
  logic                       final_last;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    node_d = '0;
    for (int i = 0; i < NUM_OPERANDS / 2; i++) begin
      node_d[i*SUM_WIDTH +: SUM_WIDTH] =
        {{LEVELS{1'b0}}, in_operands[2*i*WIDTH +: WIDTH]} +
        {{LEVELS{1'b0}}, in_operands[(2*i+1)*WIDTH +: WIDTH]};
    end
    for (int k = 2; k <= LEVELS; k++) begin
      for (int i = 0; i < (NUM_OPERANDS >> k); i++) begin
        node_d[level_base(k) + i*SUM_WIDTH +: SUM_WIDTH] =
          node_q[level_base(k-1) + 2*i*SUM_WIDTH +: SUM_WIDTH] +
          node_q[level_base(k-1) + (2*i+1)*SUM_WIDTH +: SUM_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      node_q     <= node_d;
      stage_last <= (stage_last << 1) | LEVELS'(in_last);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
    end else if (advance) begin
      stage_valid <= (stage_valid << 1) | LEVELS'(in_valid);
    end
  end

  assign final_valid = stage_valid[LEVELS-1];
  assign final_last  = stage_last[LEVELS-1];
  assign tree_sum    = node_q[TOP_BASE +: SUM_WIDTH];
  assign total       = {1'b0, acc} + {{PAD{1'b0}}, tree_sum};
  assign carry       = total[ACC_WIDTH];
  assign sat_sum     = carry ? {ACC_WIDTH{1'b1}} : total[ACC_WIDTH-1:0];

  // A last beat publishes the packet total and clears the accumulator in the same edge,
  // so the next packet can follow without an idle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
    end else if (advance) begin
      if (final_valid && final_last) begin
        out_sum      <= sat_sum;
        out_overflow <= ovf | carry;
        out_valid    <= 1'b1;
        acc          <= '0;
        ovf          <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        if (final_valid) begin
          acc <= sat_sum;
          ovf <= ovf | carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree: default 8x3-bit instance plus a 2x3-bit
// instance with a 4-bit result for the exhaustive two-operand regression.
module tb_pipelined_adder_tree;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_operands;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_sum;
  logic        out_overflow;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [5:0]  b_in_operands;
  logic        b_in_last;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [3:0]  b_out_sum;
  logic        b_out_overflow;

  int compared;
  int mismatched;

  logic [7:0] q_sum[$];
  logic       q_ovf[$];
  logic [3:0] b_q_sum[$];
  logic       b_q_ovf[$];

  pipelined_adder_tree #(.WIDTH(3), .NUM_OPERANDS(8), .ACC_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_operands(in_operands), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_overflow(out_overflow)
  );

  pipelined_adder_tree #(.WIDTH(3), .NUM_OPERANDS(2), .ACC_WIDTH(4)) dut_pair (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_operands(b_in_operands), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum), .out_overflow(b_out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed result handshake; inputs change only just after rising edges.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_sum.push_back(out_sum);
      q_ovf.push_back(out_overflow);
    end
    if (!rst && b_out_valid && b_out_ready) begin
      b_q_sum.push_back(b_out_sum);
      b_q_ovf.push_back(b_out_overflow);
    end
  end

  function automatic logic [23:0] fill(input logic [2:0] v);
    logic [23:0] r;
    for (int i = 0; i < 8; i++) r[i*3 +: 3] = v;
    return r;
  endfunction

  task automatic go_idle(input int cycles);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a beat and holds it until the handshake completes; returns just after that edge.
  task automatic drive_beat(input logic [23:0] ops, input logic last);
    logic ready_seen;
    int   waited;
    in_valid    = 1'b1;
    in_operands = ops;
    in_last     = last;
    ready_seen  = 1'b0;
    waited      = 0;
    while (!ready_seen && waited < 50) begin
      @(negedge clk);
      ready_seen = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!ready_seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drive_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    compared++;
    if (out_sum !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_sum: got %0d, required 0", out_sum);
    end
    compared++;
    if (out_overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_overflow: got %b, required 0", out_overflow);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    compared++;
    if (b_out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_pair_out_valid: got %b, required 0", b_out_valid);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_beat();
    q_sum.delete();
    q_ovf.delete();
    drive_beat(fill(3'd7), 1'b1);
    in_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL single_latency_early: edge+%0d out_valid=%b, required 0", n, out_valid);
      end
      @(posedge clk);
      #1;
    end
    compared++;
    if (out_valid !== 1'b1 || out_sum !== 8'd56 || out_overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_result: valid=%b sum=%0d ovf=%b, required 1/56/0",
               out_valid, out_sum, out_overflow);
    end
    @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_drop: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_pair_regression();
    b_q_sum.delete();
    b_q_ovf.delete();
    for (int j = 0; j < 64; j++) begin
      b_in_valid    = 1'b1;
      b_in_last     = 1'b1;
      b_in_operands = {3'(j % 8), 3'(j / 8)};
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    compared++;
    if (b_q_sum.size() != 64) begin
      mismatched++;
      $display("[TB] FAIL pair_count: got %0d results, required 64", b_q_sum.size());
    end
    for (int j = 0; j < 64 && j < b_q_sum.size(); j++) begin
      compared++;
      if (b_q_sum[j] !== 4'((j / 8) + (j % 8)) || b_q_ovf[j] !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL pair_sum[%0d]: got %0d ovf %b, required %0d ovf 0",
                 j, b_q_sum[j], b_q_ovf[j], (j / 8) + (j % 8));
      end
    end
  endtask

  task automatic test_multi_beat();
    q_sum.delete();
    q_ovf.delete();
    drive_beat(fill(3'd7), 1'b0);
    drive_beat(fill(3'd7), 1'b0);
    drive_beat(fill(3'd7), 1'b1);
    go_idle(8);
    compared++;
    if (q_sum.size() != 1) begin
      mismatched++;
      $display("[TB] FAIL multi_count: got %0d results, required 1", q_sum.size());
    end else begin
      compared++;
      if (q_sum[0] !== 8'd168 || q_ovf[0] !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL multi_sum: got %0d ovf %b, required 168 ovf 0", q_sum[0], q_ovf[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    q_sum.delete();
    q_ovf.delete();
    for (int n = 0; n < 5; n++) drive_beat(fill(3'd7), n == 4);
    drive_beat(fill(3'd1), 1'b1);
    go_idle(8);
    compared++;
    if (q_sum.size() != 2) begin
      mismatched++;
      $display("[TB] FAIL sat_count: got %0d results, required 2", q_sum.size());
    end else begin
      compared++;
      if (q_sum[0] !== 8'd255 || q_ovf[0] !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL sat_first: got %0d ovf %b, required 255 ovf 1", q_sum[0], q_ovf[0]);
      end
      compared++;
      if (q_sum[1] !== 8'd8 || q_ovf[1] !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL sat_second: got %0d ovf %b, required 8 ovf 0", q_sum[1], q_ovf[1]);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_sum [10];
    logic [23:0] ops;
    int idx;
    exp_sum = '{8'd0, 8'd8, 8'd16, 8'd24, 8'd32, 8'd40, 8'd48, 8'd56, 8'd7, 8'd14};
    q_sum.delete();
    q_ovf.delete();
    fork
      begin
        for (int p = 0; p < 10; p++) begin
          ops = fill(3'(p % 8));
          ops[2:0] = (p < 8) ? 3'(p % 8) : 3'd7;
          drive_beat(ops, 1'b1);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          idx = q_sum.size();
          compared++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL stall_handshake: cycle %0d in_ready=%b out_valid=%b, required 0/1",
                     c, in_ready, out_valid);
          end
          compared++;
          if (idx > 9 || out_sum !== exp_sum[idx % 10]) begin
            mismatched++;
            $display("[TB] FAIL stall_hold: cycle %0d out_sum=%0d, required %0d",
                     c, out_sum, exp_sum[idx % 10]);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    go_idle(10);
    compared++;
    if (q_sum.size() != 10) begin
      mismatched++;
      $display("[TB] FAIL stall_count: got %0d results, required 10", q_sum.size());
    end
    for (int p = 0; p < 10 && p < q_sum.size(); p++) begin
      compared++;
      if (q_sum[p] !== exp_sum[p] || q_ovf[p] !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL stall_result[%0d]: got %0d ovf %b, required %0d ovf 0",
                 p, q_sum[p], q_ovf[p], exp_sum[p]);
      end
    end
  endtask

  task automatic test_reset_abort();
    q_sum.delete();
    q_ovf.delete();
    drive_beat(fill(3'd7), 1'b0);
    drive_beat(fill(3'd7), 1'b0);
    go_idle(4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || out_sum !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL abort_reset_state: valid=%b sum=%0d, required 0/0", out_valid, out_sum);
    end
    drive_beat(fill(3'd1), 1'b1);
    go_idle(8);
    compared++;
    if (q_sum.size() != 1) begin
      mismatched++;
      $display("[TB] FAIL abort_count: got %0d results, required 1", q_sum.size());
    end else begin
      compared++;
      if (q_sum[0] !== 8'd8 || q_ovf[0] !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL abort_sum: got %0d ovf %b, required 8 ovf 0", q_sum[0], q_ovf[0]);
      end
    end
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_operands   = '0;
    in_last       = 1'b0;
    out_ready     = 1'b1;
    b_in_valid    = 1'b0;
    b_in_operands = '0;
    b_in_last     = 1'b0;
    b_out_ready   = 1'b1;
    test_reset();
    test_single_beat();
    test_pair_regression();
    test_multi_beat();
    test_back_to_back();
    test_stall();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
